md_sched: RTL
=============

Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage.
- Accepts one mult/multu/div/divu op from EX and latches its operands.
- Drives the shared mul unit and the radix-2 div unit, holds the pipeline via a stall request, then issues a one-cycle HI/LO write.
- Sits between EX decode and the mul, div and hilo instances; replaces the ad-hoc combinational div start/stall logic.

Parameters:
MUL_LAT, 2, cycles from mul operand presentation to a valid mul_result (min 1)
DIVZ_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
op_valid  in  1  EX holds a mul/div op this cycle
op_type  in  2  00 mult, 01 multu, 10 div, 11 divu
opa  in  32  rs operand
opb  in  32  rt operand
flush  in  1  kill any in-flight op
ex_hold  in  1  EX stalled by another source; EX contents will not advance
mul_signed  out  1  to mul
mul_ina  out  32  to mul
mul_inb  out  32  to mul
mul_result  in  64  from mul, {hi,lo}
div_signed  out  1  to div
div_opdata1  out  32  to div
div_opdata2  out  32  to div
div_start  out  1  to div
div_annul  out  1  to div
div_result  in  64  from div, {remainder,quotient}
div_ready  in  1  div result valid
stallreq  out  1  request pipeline stall
hilo_we  out  1  HI/LO write strobe
hilo_data  out  64  {hi,lo}
busy  out  1  state != IDLE

Behaviour:
- Reset: async on resetn low. State IDLE; counter, operand and result regs cleared; every output 0.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE, on op_valid & !flush: latch opa, opb, op_type.
  - op_type[1]=0: go to MUL_WAIT and load the counter with MUL_LAT-1.
  - op_type[1]=1, opb!=0: go to DIV_RUN.
  - op_type[1]=1, opb==0: go to DONE with the result set to {opa, DIVZ_LO}. The divider is not started.
- MUL_WAIT: counter decrements each cycle. At 0, capture mul_result and go to DONE.
- DIV_RUN: div_start=1 until the cycle div_ready=1. In that cycle capture div_result and go to DONE. div_start is 0 from DONE onward.
- DONE: hilo_we=1 only in the first DONE cycle. hilo_data is always the registered result.
  - Stay in DONE while ex_hold=1, ignoring op_valid, so a held instruction is not re-issued.
  - When ex_hold=0, go to IDLE.
- Mul/div operand outputs come from the latched regs while busy. All are 0 in IDLE. mul_signed = !op_type[0]; div_signed = !op_type[0].
- stallreq = (IDLE & op_valid & !flush) | MUL_WAIT | DIV_RUN. It is combinational and stays low in DONE.
- Latency, with issue in cycle T:
  - mul: hilo_we at T+1+MUL_LAT.
  - div by zero: hilo_we at T+1.
  - div: hilo_we one cycle after the div_ready cycle.
- flush (synchronous, any state): go to IDLE next cycle with no hilo_we. If the state is DIV_RUN, div_annul=1 for that cycle. flush beats div_ready or counter expiry in the same cycle. flush in IDLE with op_valid: no issue.
- resetn low mid-operation: immediate IDLE with outputs 0. div_annul is not required; the div unit shares the reset.
- Back-to-back ops: the next op is accepted on the first IDLE cycle after DONE.

Decomposition:
- Shared defines header:
  - op_type encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state encodings
  - reuse the existing Stop/NoStop and DivStart/DivStop constants
- No sub-module. The single FSM plus counter is self-contained; mul, div and hilo are instantiated by EX.

Test Plan:
- mult opa=32'hFFFF_FFFE, opb=3, MUL_LAT=2, issue T -> stallreq 1 for T..T+2; hilo_we only at T+3 with hilo_data=64'hFFFF_FFFF_FFFF_FFFA.
- divu opa=100, opb=7; div model asserts ready 33 cycles after start -> div_start held until ready; hilo_we the next cycle with hilo_data={32'd2,32'd14}.
- div opa=-7, opb=0 -> no div_start; hilo_we at T+1 with hilo_data={32'hFFFF_FFF9,32'hFFFF_FFFF}.
- div in DIV_RUN, flush asserted in the same cycle as div_ready -> div_annul pulse, no hilo_we, state IDLE, stallreq 0.
- mult completes while ex_hold=1 for 3 cycles with op_valid still high -> exactly one hilo_we, no re-issue; next op accepted after ex_hold drops.
- resetn pulsed low asynchronously mid DIV_RUN -> all outputs 0 immediately, busy 0; a fresh multu 5*6 then yields 64'd30.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package md_sched_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    // Bit 0 of the op type distinguishes the unsigned variants.
    function automatic logic md_is_signed(input logic [1:0] t);
        return ~t[0];
    endfunction

endpackage

// File: rtl/md_sched.sv
// Multi-cycle mult/div sequencer: latches one op, drives mul/div, stalls EX,
// then issues a single HI/LO write.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned         MUL_LAT = 2,
    parameter logic [DATA_W-1:0]   DIVZ_LO = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  op_valid,
    input  logic [1:0]            op_type,
    input  logic [DATA_W-1:0]     opa,
    input  logic [DATA_W-1:0]     opb,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  mul_signed,
    output logic [DATA_W-1:0]     mul_ina,
    output logic [DATA_W-1:0]     mul_inb,
    input  logic [2*DATA_W-1:0]   mul_result,
    output logic                  div_signed,
    output logic [DATA_W-1:0]     div_opdata1,
    output logic [DATA_W-1:0]     div_opdata2,
    output logic                  div_start,
    output logic                  div_annul,
    input  logic [2*DATA_W-1:0]   div_result,
    input  logic                  div_ready,
    output logic                  stallreq,
    output logic                  hilo_we,
    output logic [2*DATA_W-1:0]   hilo_data,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    md_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_W-1:0]      opa_q, opb_q;
    logic                   sgn_q;
    logic [2*DATA_W-1:0]    res_q;
    logic                   div_start_q, hilo_we_q, busy_q;
    logic                   issue_c, op_div_c, divz_c;

    assign op_div_c = (op_type == MD_DIV) || (op_type == MD_DIVU);
    assign divz_c   = op_div_c && (opb == '0);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state, stall request and annul; flush overrides every transition
    always_comb begin
        state_d   = state_q;
        issue_c   = 1'b0;
        stallreq  = NO_STOP;
        div_annul = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    issue_c  = 1'b1;
                    stallreq = STOP;
                    if (!op_div_c)   state_d = ST_MUL_WAIT;
                    else if (divz_c) state_d = ST_DONE;
                    else             state_d = ST_DIV_RUN;
                end
            end
            ST_MUL_WAIT: begin
                stallreq = STOP;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DIV_RUN: begin
                stallreq  = STOP;
                div_annul = flush;
                if (div_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!ex_hold) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
        if (!resetn) stallreq = NO_STOP;
    end

    // Operand latch, latency counter, result capture and registered strobes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sgn_q       <= 1'b0;
            res_q       <= '0;
            div_start_q <= DIV_STOP;
            hilo_we_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hilo_we_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
            div_start_q <= (state_d == ST_DIV_RUN) ? DIV_START : DIV_STOP;
            busy_q      <= (state_d != ST_IDLE);

            if (state_d == ST_IDLE) begin
                cnt_q <= '0;
                opa_q <= '0;
                opb_q <= '0;
                sgn_q <= 1'b0;
            end else if (issue_c) begin
                cnt_q <= CNT_INIT;
                opa_q <= opa;
                opb_q <= opb;
                sgn_q <= md_is_signed(op_type);
            end else if ((state_q == ST_MUL_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (issue_c && divz_c)
                res_q <= {opa, DIVZ_LO};
            else if ((state_q == ST_MUL_WAIT) && (state_d == ST_DONE))
                res_q <= mul_result;
            else if ((state_q == ST_DIV_RUN) && (state_d == ST_DONE))
                res_q <= div_result;
        end
    end

    assign mul_signed  = sgn_q;
    assign mul_ina     = opa_q;
    assign mul_inb     = opb_q;
    assign div_signed  = sgn_q;
    assign div_opdata1 = opa_q;
    assign div_opdata2 = opb_q;
    assign div_start   = div_start_q;
    assign hilo_we     = hilo_we_q;
    assign hilo_data   = res_q;
    assign busy        = busy_q;

endmodule
